vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_if.sv | 17 +
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster types and the 800x600@60 timing constants (40 MHz pixel clock).
// Pure declarations: no latency, no flow control.
package vga_pkg;

  typedef logic [10:0] cnt_t;

  localparam cnt_t HOR_PIXELS    = 11'd800;
  localparam cnt_t H_FRONT_CLKS  = 11'd40;
  localparam cnt_t H_SYNC_CLKS   = 11'd128;
  localparam cnt_t H_BACK_CLKS   = 11'd88;
  localparam cnt_t H_TOTAL_CLKS  = HOR_PIXELS + H_FRONT_CLKS + H_SYNC_CLKS + H_BACK_CLKS;

  localparam cnt_t VER_PIXELS    = 11'd600;
  localparam cnt_t V_FRONT_LINES = 11'd1;
  localparam cnt_t V_SYNC_LINES  = 11'd4;
  localparam cnt_t V_BACK_LINES  = 11'd23;
  localparam cnt_t V_TOTAL_LINES = VER_PIXELS + V_FRONT_LINES + V_SYNC_LINES + V_BACK_LINES;

  // Half-open window test [lo, hi), used for both sync pulses.
  function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-stream bundle passed along the draw chain: raster position, sync/blank flags, colour.
// Plain wires: no latency, no backpressure (the stream runs at one pixel per enabled clock).
interface vga_if;
  import vga_pkg::*;

  cnt_t        hcount;
  logic        hsync;
  logic        hblnk;
  cnt_t        vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_timing_gen.sv
// Raster source: counters, sync/blank flags and frame_start, all registered from next-state values (1 cycle).
// No backpressure; en=0 freezes the raster and holds every output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter cnt_t H_ACTIVE = HOR_PIXELS,
  parameter cnt_t H_FRONT  = H_FRONT_CLKS,
  parameter cnt_t H_SYNC   = H_SYNC_CLKS,
  parameter cnt_t H_BACK   = H_BACK_CLKS,
  parameter cnt_t V_ACTIVE = VER_PIXELS,
  parameter cnt_t V_FRONT  = V_FRONT_LINES,
  parameter cnt_t V_SYNC   = V_SYNC_LINES,
  parameter cnt_t V_BACK   = V_BACK_LINES,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic frame_start,
  vga_if.out   out
);

  localparam cnt_t H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam cnt_t V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam cnt_t H_LAST   = H_TOTAL - 11'd1;
  localparam cnt_t V_LAST   = V_TOTAL - 11'd1;
  localparam cnt_t HS_START = H_ACTIVE + H_FRONT;
  localparam cnt_t HS_END   = HS_START + H_SYNC;
  localparam cnt_t VS_START = V_ACTIVE + V_FRONT;
  localparam cnt_t VS_END   = VS_START + V_SYNC;

  cnt_t hcount_q, hcount_d;
  cnt_t vcount_q, vcount_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic hblnk_q, hblnk_d;
  logic vblnk_q, vblnk_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  // Flags decode the next-state position so they land in the same cycle as the count they describe.
  // With en=0 the next state equals the current one, so the flags hold on their own.
  always_comb begin
    hblnk_d       = (hcount_d >= H_ACTIVE);
    vblnk_d       = (vcount_d >= V_ACTIVE);
    hsync_d       = in_window(hcount_d, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = in_window(vcount_d, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = en && (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign out.hcount  = hcount_q;
  assign out.vcount  = vcount_q;
  assign out.hsync   = hsync_q;
  assign out.vsync   = vsync_q;
  assign out.hblnk   = hblnk_q;
  assign out.vblnk   = vblnk_q;
  assign out.rgb     = 12'h000;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 800x600 instance plus a tiny inverted-sync instance
// that wraps whole frames quickly; both are checked every cycle against a pixel-index model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  // Small instance geometry: 15 clocks per line, 10 lines per frame.
  localparam int BH_A = 8, BH_F = 2, BH_S = 3, BH_B = 2;
  localparam int BV_A = 5, BV_F = 1, BV_S = 2, BV_B = 2;
  localparam int A_TOT = 1056 * 628;
  localparam int B_TOT = (BH_A + BH_F + BH_S + BH_B) * (BV_A + BV_F + BV_S + BV_B);

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic fs_a, fs_b;
  int   checks = 0;
  int   failures = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  vga_if a_if ();
  vga_if b_if ();

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(fs_a), .out(a_if)
  );

  vga_timing_gen #(
    .H_ACTIVE(11'd8), .H_FRONT(11'd2), .H_SYNC(11'd3), .H_BACK(11'd2),
    .V_ACTIVE(11'd5), .V_FRONT(11'd1), .V_SYNC(11'd2), .V_BACK(11'd2),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(fs_b), .out(b_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for linear pixel index p of a frame with the given geometry.
  function automatic obs_t expect_at(input int p, input bit fs,
                                     input int ha, input int hf, input int hsw, input int hbk,
                                     input int va, input int vf, input int vsw, input int vbk,
                                     input bit pol);
    obs_t e;
    int ht, h, v;
    ht    = ha + hf + hsw + hbk;
    h     = p % ht;
    v     = p / ht;
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.hb  = (h >= ha);
    e.vb  = (v >= va);
    e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : !pol;
    e.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : !pol;
    e.fs  = fs;
    e.rgb = 12'h000;
    return e;
  endfunction

  // Model: each instance is just a pixel index that advances on every enabled clock.
  int pa, pb;
  bit fsa, fsb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa <= 0; pb <= 0; fsa <= 1'b0; fsb <= 1'b0;
    end else if (en) begin
      pa  <= (pa + 1) % A_TOT;
      pb  <= (pb + 1) % B_TOT;
      fsa <= ((pa + 1) % A_TOT) == 0;
      fsb <= ((pb + 1) % B_TOT) == 0;
    end else begin
      fsa <= 1'b0; fsb <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      obs_t oa, ob;
      oa = {a_if.hcount, a_if.vcount, a_if.hsync, a_if.hblnk, a_if.vsync, a_if.vblnk, fs_a, a_if.rgb};
      ob = {b_if.hcount, b_if.vcount, b_if.hsync, b_if.hblnk, b_if.vsync, b_if.vblnk, fs_b, b_if.rgb};
      check("cycle_big", 64'(oa), 64'(expect_at(pa, fsa, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1)));
      check("cycle_small", 64'(ob),
            64'(expect_at(pb, fsb, BH_A, BH_F, BH_S, BH_B, BV_A, BV_F, BV_S, BV_B, 1'b0)));
    end
  end

  task automatic wait_big_h(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (int'(a_if.hcount) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(a_if.hcount), 64'(target));
  endtask

  initial begin
    int n, hs_cnt, hs_first, hs_last, fs_cnt;
    en    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_hcount", 64'(a_if.hcount), 64'd0);
    check("rst_vcount", 64'(a_if.vcount), 64'd0);
    check("rst_sync", {62'd0, a_if.hsync, a_if.vsync}, 64'd0);
    check("rst_blnk", {62'd0, a_if.hblnk, a_if.vblnk}, 64'd0);
    check("rst_fs", {62'd0, fs_a, fs_b}, 64'd0);
    check("rst_small_sync_idle", {62'd0, b_if.hsync, b_if.vsync}, 64'd3);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check("first_edge_hcount", 64'(a_if.hcount), 64'd1);

    // One full line of the big raster.
    wait_big_h(799, 2000, "reach_799");
    check("hblnk_799", 64'(a_if.hblnk), 64'd0);
    @(negedge clk);
    check("hblnk_800", {63'd0, a_if.hblnk}, 64'd1);
    hs_cnt = 0; hs_first = -1; hs_last = -1; n = 0;
    while (a_if.hcount != 11'd1055 && n < 2000) begin
      @(negedge clk);
      n++;
      if (a_if.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_if.hcount);
        hs_last = int'(a_if.hcount);
      end
    end
    check("reach_1055", 64'(a_if.hcount), 64'd1055);
    check("hsync_width", 64'(hs_cnt), 64'd128);
    check("hsync_first", 64'(hs_first), 64'd840);
    check("hsync_last", 64'(hs_last), 64'd967);
    @(negedge clk);
    check("wrap_hcount", 64'(a_if.hcount), 64'd0);
    check("wrap_vcount", 64'(a_if.vcount), 64'd1);

    // Stall at hcount 500.
    wait_big_h(500, 2000, "reach_500");
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hcount", 64'(a_if.hcount), 64'd500);
      check("stall_fs", {62'd0, fs_a, fs_b}, 64'd0);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume_501", 64'(a_if.hcount), 64'd501);
    @(negedge clk);
    check("resume_502", 64'(a_if.hcount), 64'd502);

    // Random enable pattern; the per-cycle compare carries the checking.
    repeat (20000) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
    end
    en = 1'b1;

    // Asynchronous reset mid-line, between clock edges.
    wait_big_h(700, 2000, "reach_700");
    #2 rst_n = 1'b0;
    #1;
    check("arst_hcount", 64'(a_if.hcount), 64'd0);
    check("arst_vcount", 64'(a_if.vcount), 64'd0);
    check("arst_big_flags", {60'd0, a_if.hsync, a_if.vsync, a_if.hblnk, a_if.vblnk}, 64'd0);
    check("arst_small_sync", {62'd0, b_if.hsync, b_if.vsync}, 64'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Small raster: first frame_start exactly one frame after release, then once per frame.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_b && n < 400);
    check("frame_period_after_rst", 64'(n), 64'd150);
    fs_cnt = 0;
    repeat (3 * 150) begin
      @(negedge clk);
      if (fs_b) fs_cnt++;
    end
    check("frame_start_count", 64'(fs_cnt), 64'd3);
    check("frame_start_at_origin", {b_if.hcount, b_if.vcount}, 64'd0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
